// File: rtl/fx2_slave_fifo_model_pkg.sv
// rtl/fx2_slave_fifo_model_pkg.sv - shared constants and types for the FX2 slave-FIFO model
package fx2_model_pkg;

    localparam logic [1:0] EP2_ADDR = 2'b00;
    localparam logic [1:0] EP6_ADDR = 2'b10;

    localparam int FLAG_EP2_EMPTY_N = 0;
    localparam int FLAG_EP6_FULL_N  = 1;
    localparam int FLAG_EP6_AFULL_N = 2;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } ep6_entry_t;

endpackage

// File: rtl/fx2_slave_fifo_model_if.sv
// rtl/fx2_slave_fifo_model_if.sv - FX2 slave-FIFO strobe/flag bundle
interface fx2_slave_fifo_model_if;
    logic [1:0] fx2_fifoadr;
    logic       fx2_slrd;
    logic       fx2_slwr;
    logic       fx2_sloe;
    logic       fx2_pktend;
    logic [2:0] fx2_flags;

    modport master (
        output fx2_fifoadr, fx2_slrd, fx2_slwr, fx2_sloe, fx2_pktend,
        input  fx2_flags
    );

    modport slave (
        input  fx2_fifoadr, fx2_slrd, fx2_slwr, fx2_sloe, fx2_pktend,
        output fx2_flags
    );
endinterface

// File: rtl/fx2_slave_fifo_model_ep_fifo.sv
// rtl/fx2_slave_fifo_model_ep_fifo.sv - generic synchronous FIFO with occupancy count
module fx2_ep_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance for accepted pushes and pops.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end
endmodule

// File: rtl/fx2_slave_fifo_model.sv
// rtl/fx2_slave_fifo_model.sv - FX2 slave-FIFO endpoint emulation (EP2 OUT, EP6 IN)
module fx2_slave_fifo_model
    import fx2_model_pkg::*;
#(
    parameter int DEPTH       = 512,
    parameter int PKT_SIZE    = 512,
    parameter int AFULL_LEVEL = 480
) (
    input  logic                   fx2_clk,
    input  logic                   reset_n,
    fx2_slave_fifo_model_if.slave  fx2,
    inout  wire  [7:0]             fx2_fd,
    input  logic [7:0]             host_out_data,
    input  logic                   host_out_valid,
    output logic                   host_out_ready,
    output logic [7:0]             host_in_data,
    output logic                   host_in_last,
    output logic                   host_in_valid,
    input  logic                   host_in_ready,
    output logic                   host_in_zlp,
    output logic                   err_underrun,
    output logic                   err_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int UW = $clog2(PKT_SIZE) + 1;
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_LEVEL);
    localparam logic [UW-1:0] UCNT_PKT  = UW'(PKT_SIZE);

    // ---------------- EP2 (host -> master) ----------------
    logic          ep2_rd_req, ep2_drive, ep2_full, ep2_empty;
    logic [7:0]    ep2_head, fd_out;
    logic [CW-1:0] ep2_count;

    assign ep2_rd_req     = !fx2.fx2_slrd && (fx2.fx2_fifoadr == EP2_ADDR);
    assign ep2_drive      = !fx2.fx2_sloe && (fx2.fx2_fifoadr == EP2_ADDR);
    assign host_out_ready = !ep2_full;
    assign fd_out         = ep2_empty ? 8'h00 : ep2_head;
    assign fx2_fd         = ep2_drive ? fd_out : 8'hzz;

    fx2_ep_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_ep2 (
        .clk     (fx2_clk),
        .resetn  (reset_n),
        .wr_en   (host_out_valid && host_out_ready),
        .wr_data (host_out_data),
        .rd_en   (ep2_rd_req),
        .rd_data (ep2_head),
        .count   (ep2_count),
        .full    (ep2_full),
        .empty   (ep2_empty)
    );

    // ---------------- EP6 (master -> host) ----------------
    logic [CW-1:0] ep6_wr_ptr_q, ep6_wr_ptr_d;
    logic [CW-1:0] ep6_rd_ptr_q, ep6_rd_ptr_d;
    logic [CW-1:0] ep6_cptr_q, ep6_cptr_d;
    logic [UW-1:0] ucnt_q, ucnt_d, ucnt_inc;
    logic [CW-1:0] ep6_count;
    logic [AW-1:0] ep6_waddr, ep6_laddr;
    ep6_entry_t    ep6_mem_q [DEPTH];
    ep6_entry_t    ep6_head, ep6_wr_entry;
    logic          ep6_wr_req, ep6_pkt_req, ep6_full, ep6_wr_ok;
    logic          auto_commit, pkt_commit, commit, host_pop;
    logic          zlp_q, zlp_d;
    logic          err_underrun_q, err_underrun_d, err_overflow_q, err_overflow_d;
    logic [2:0]    flags_q, flags_d;

    assign ep6_wr_req  = !fx2.fx2_slwr   && (fx2.fx2_fifoadr == EP6_ADDR);
    assign ep6_pkt_req = !fx2.fx2_pktend && (fx2.fx2_fifoadr == EP6_ADDR);
    assign ep6_full    = (ep6_wr_ptr_q[AW] != ep6_rd_ptr_q[AW]) &&
                         (ep6_wr_ptr_q[AW-1:0] == ep6_rd_ptr_q[AW-1:0]);
    assign ep6_count   = ep6_wr_ptr_q - ep6_rd_ptr_q;
    assign ep6_waddr   = ep6_wr_ptr_q[AW-1:0];
    assign ep6_laddr   = ep6_waddr - {{(AW-1){1'b0}}, 1'b1};
    assign ep6_head    = ep6_mem_q[ep6_rd_ptr_q[AW-1:0]];

    // Only committed bytes (behind cptr) are visible to the host.
    assign host_in_valid = (ep6_rd_ptr_q != ep6_cptr_q);
    assign host_in_data  = ep6_head.data;
    assign host_in_last  = host_in_valid && ep6_head.last;
    assign host_pop      = host_in_valid && host_in_ready;

    // Write/commit decision: a same-edge write counts before pktend looks at ucnt.
    always_comb begin
        ep6_wr_ok    = ep6_wr_req && !ep6_full;
        ucnt_inc     = ucnt_q + {{(UW-1){1'b0}}, ep6_wr_ok};
        auto_commit  = ep6_wr_ok && (ucnt_inc == UCNT_PKT);
        pkt_commit   = ep6_pkt_req && (ucnt_inc != '0);
        commit       = auto_commit || pkt_commit;
        zlp_d        = ep6_pkt_req && (ucnt_inc == '0);
        ep6_wr_ptr_d = ep6_wr_ptr_q + {{AW{1'b0}}, ep6_wr_ok};
        ep6_rd_ptr_d = ep6_rd_ptr_q + {{AW{1'b0}}, host_pop};
        ep6_cptr_d   = commit ? ep6_wr_ptr_d : ep6_cptr_q;
        ucnt_d       = commit ? '0 : ucnt_inc;
        ep6_wr_entry = '{last: commit, data: fx2_fd};
    end

    // Sticky errors and registered flags computed from the current state.
    always_comb begin
        err_underrun_d = err_underrun_q || (ep2_rd_req && ep2_empty);
        err_overflow_d = err_overflow_q || (ep6_wr_req && ep6_full);
        flags_d                   = '0;
        flags_d[FLAG_EP2_EMPTY_N] = (ep2_count != '0);
        flags_d[FLAG_EP6_FULL_N]  = (ep6_count != CNT_DEPTH);
        flags_d[FLAG_EP6_AFULL_N] = (ep6_count < CNT_AFULL);
    end

    // EP6 pointers, packet state, flags and error registers.
    always_ff @(posedge fx2_clk) begin
        if (!reset_n) begin
            ep6_wr_ptr_q   <= '0;
            ep6_rd_ptr_q   <= '0;
            ep6_cptr_q     <= '0;
            ucnt_q         <= '0;
            zlp_q          <= 1'b0;
            err_underrun_q <= 1'b0;
            err_overflow_q <= 1'b0;
            flags_q        <= 3'b110;
        end else begin
            ep6_wr_ptr_q   <= ep6_wr_ptr_d;
            ep6_rd_ptr_q   <= ep6_rd_ptr_d;
            ep6_cptr_q     <= ep6_cptr_d;
            ucnt_q         <= ucnt_d;
            zlp_q          <= zlp_d;
            err_underrun_q <= err_underrun_d;
            err_overflow_q <= err_overflow_d;
            flags_q        <= flags_d;
        end
    end

    // EP6 storage: new byte, or last-bit write-back on the newest byte for pktend.
    always_ff @(posedge fx2_clk) begin
        if (ep6_wr_ok) begin
            ep6_mem_q[ep6_waddr] <= ep6_wr_entry;
        end else if (pkt_commit) begin
            ep6_mem_q[ep6_laddr].last <= 1'b1;
        end
    end

    assign host_in_zlp   = zlp_q;
    assign err_underrun  = err_underrun_q;
    assign err_overflow  = err_overflow_q;
    assign fx2.fx2_flags = flags_q;
endmodule

// File: tb/tb_fx2_slave_fifo_model.sv
// tb/tb_fx2_slave_fifo_model.sv - scoreboard bench for the FX2 slave-FIFO model
module tb_fx2_slave_fifo_model;
    import fx2_model_pkg::*;

    logic fx2_clk = 1'b0;
    always #5 fx2_clk = ~fx2_clk;

    logic       reset_n;
    fx2_slave_fifo_model_if bus();
    wire  [7:0] fx2_fd;
    logic [7:0] tb_fd;
    logic       tb_fd_en;
    assign fx2_fd = tb_fd_en ? tb_fd : 8'hzz;

    logic [7:0] host_out_data;
    logic       host_out_valid, host_out_ready;
    logic [7:0] host_in_data;
    logic       host_in_last, host_in_valid, host_in_ready, host_in_zlp;
    logic       err_underrun, err_overflow;

    int errors = 0;
    int checks = 0;
    logic [7:0] ep2_exp[$];
    logic [8:0] ep6_exp[$];
    logic [8:0] mon_e6;
    logic [7:0] mon_e2;

    fx2_slave_fifo_model dut (
        .fx2_clk        (fx2_clk),
        .reset_n        (reset_n),
        .fx2            (bus),
        .fx2_fd         (fx2_fd),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .host_in_data   (host_in_data),
        .host_in_last   (host_in_last),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .host_in_zlp    (host_in_zlp),
        .err_underrun   (err_underrun),
        .err_overflow   (err_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare host-side EP6 bytes and EP2 bytes seen on fd at each read strobe.
    always @(negedge fx2_clk) begin
        if (reset_n) begin
            if (host_in_valid && host_in_ready) begin
                if (ep6_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL host_in unexpected: got %0h expected none", {host_in_last, host_in_data});
                end else begin
                    mon_e6 = ep6_exp.pop_front();
                    check("host_in", 32'({host_in_last, host_in_data}), 32'(mon_e6));
                end
            end
            if (!bus.fx2_slrd && !bus.fx2_sloe && bus.fx2_fifoadr == EP2_ADDR && ep2_exp.size() != 0) begin
                mon_e2 = ep2_exp.pop_front();
                check("ep2_fd", 32'(fx2_fd), 32'(mon_e2));
            end
        end
    end

    task automatic tick();
        @(posedge fx2_clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.fx2_fifoadr = 2'b11;
        bus.fx2_slrd    = 1'b1;
        bus.fx2_slwr    = 1'b1;
        bus.fx2_sloe    = 1'b1;
        bus.fx2_pktend  = 1'b1;
        tb_fd_en        = 1'b0;
        tb_fd           = 8'h00;
    endtask

    task automatic ep6_write(input logic [7:0] b, input bit with_end);
        bus.fx2_fifoadr = EP6_ADDR;
        tb_fd_en        = 1'b1;
        tb_fd           = b;
        bus.fx2_slwr    = 1'b0;
        bus.fx2_pktend  = with_end ? 1'b0 : 1'b1;
        tick();
        bus.fx2_slwr    = 1'b1;
        bus.fx2_pktend  = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (ep6_exp.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        check(name, 32'(ep6_exp.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        reset_n        = 1'b0;
        host_out_data  = 8'h00;
        host_out_valid = 1'b0;
        host_in_ready  = 1'b1;
        tick();
        tick();
        check("reset flags", 32'(bus.fx2_flags), 32'h6);
        check("reset host_out_ready", 32'(host_out_ready), 32'd1);
        check("reset host_in_valid", 32'(host_in_valid), 32'd0);
        check("reset host_in_last", 32'(host_in_last), 32'd0);
        check("reset zlp", 32'(host_in_zlp), 32'd0);
        check("reset errors", 32'({err_underrun, err_overflow}), 32'd0);
        reset_n = 1'b1;
        tick();

        // Command path
        host_out_valid = 1'b1;
        host_out_data = 8'hA5; ep2_exp.push_back(8'hA5); tick();
        host_out_data = 8'h3C; ep2_exp.push_back(8'h3C); tick();
        host_out_valid = 1'b0;
        tick(); tick();
        check("ep2 flag nonempty", 32'(bus.fx2_flags[FLAG_EP2_EMPTY_N]), 32'd1);
        bus.fx2_fifoadr = EP2_ADDR;
        bus.fx2_sloe    = 1'b0;
        tick();
        check("ep2 fd head", 32'(fx2_fd), 32'hA5);
        bus.fx2_slrd = 1'b0;
        tick(); tick();
        bus.fx2_slrd = 1'b1;
        tick(); tick();
        check("ep2 flag empty", 32'(bus.fx2_flags[FLAG_EP2_EMPTY_N]), 32'd0);
        check("ep2 fd empty", 32'(fx2_fd), 32'h00);
        idle_bus();
        tick();

        // Packet commit by pktend
        ep6_write(8'h01, 0);
        ep6_write(8'h02, 0);
        ep6_write(8'h03, 0);
        tick(); tick();
        check("uncommitted invisible", 32'(host_in_valid), 32'd0);
        ep6_exp.push_back({1'b0, 8'h01});
        ep6_exp.push_back({1'b0, 8'h02});
        ep6_exp.push_back({1'b1, 8'h03});
        bus.fx2_fifoadr = EP6_ADDR;
        bus.fx2_pktend  = 1'b0;
        tick();
        bus.fx2_pktend  = 1'b1;
        wait_drain("pkt commit drain");

        // ZLP with nothing pending
        bus.fx2_fifoadr = EP6_ADDR;
        bus.fx2_pktend  = 1'b0;
        tick();
        bus.fx2_pktend  = 1'b1;
        check("zlp pulse", 32'(host_in_zlp), 32'd1);
        tick();
        check("zlp one cycle", 32'(host_in_zlp), 32'd0);

        // Same-edge write + pktend
        ep6_exp.push_back({1'b1, 8'h7E});
        ep6_write(8'h7E, 1);
        check("no zlp on write+pktend", 32'(host_in_zlp), 32'd0);
        wait_drain("write+pktend drain");

        // Auto-commit at PKT_SIZE
        for (int i = 0; i < 512; i++) begin
            ep6_exp.push_back({(i == 511), 8'(i)});
            ep6_write(8'(i), 0);
        end
        wait_drain("auto commit drain");
        bus.fx2_fifoadr = EP6_ADDR;
        bus.fx2_pktend  = 1'b0;
        tick();
        bus.fx2_pktend  = 1'b1;
        check("ucnt cleared after auto commit", 32'(host_in_zlp), 32'd1);
        tick();

        // Fill EP6 to DEPTH with the host stalled
        host_in_ready = 1'b0;
        for (int i = 0; i < 512; i++) ep6_exp.push_back({(i == 511), 8'(i * 3)});
        for (int i = 0; i < 479; i++) ep6_write(8'(i * 3), 0);
        tick(); tick();
        check("afull_n at 479", 32'(bus.fx2_flags[FLAG_EP6_AFULL_N]), 32'd1);
        ep6_write(8'(479 * 3), 0);
        tick(); tick();
        check("afull_n at 480", 32'(bus.fx2_flags[FLAG_EP6_AFULL_N]), 32'd0);
        check("full_n at 480", 32'(bus.fx2_flags[FLAG_EP6_FULL_N]), 32'd1);
        for (int i = 480; i < 512; i++) ep6_write(8'(i * 3), 0);
        tick(); tick();
        check("full_n at depth", 32'(bus.fx2_flags[FLAG_EP6_FULL_N]), 32'd0);
        check("afull_n at depth", 32'(bus.fx2_flags[FLAG_EP6_AFULL_N]), 32'd0);
        check("no overflow yet", 32'(err_overflow), 32'd0);
        ep6_write(8'hEE, 0);
        tick();
        check("overflow sticky", 32'(err_overflow), 32'd1);
        host_in_ready = 1'b1;
        wait_drain("full drain");
        tick(); tick();
        check("flags after drain", 32'(bus.fx2_flags), 32'h6);

        // Underrun on empty EP2
        idle_bus();
        bus.fx2_fifoadr = EP2_ADDR;
        bus.fx2_sloe    = 1'b0;
        tick();
        check("fd empty driven", 32'(fx2_fd), 32'h00);
        check("no underrun yet", 32'(err_underrun), 32'd0);
        bus.fx2_slrd = 1'b0;
        tick();
        bus.fx2_slrd = 1'b1;
        tick();
        check("underrun sticky", 32'(err_underrun), 32'd1);
        check("ep2 still empty", 32'(bus.fx2_flags[FLAG_EP2_EMPTY_N]), 32'd0);

        // EP2 wrap with simultaneous push/pop
        host_out_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_out_data = 8'(i * 7 + 1);
            ep2_exp.push_back(8'(i * 7 + 1));
            tick();
        end
        bus.fx2_slrd = 1'b0;
        for (int i = 4; i < 1540; i++) begin
            host_out_data = 8'(i * 7 + 1);
            ep2_exp.push_back(8'(i * 7 + 1));
            tick();
        end
        host_out_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.fx2_slrd = 1'b1;
        tick(); tick();
        check("ep2 empty after wrap", 32'(bus.fx2_flags[FLAG_EP2_EMPTY_N]), 32'd0);
        idle_bus();

        // EP6 wrap with 100-byte packets
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 100; i++) begin
                ep6_exp.push_back({(i == 99), 8'(p * 100 + i)});
                ep6_write(8'(p * 100 + i), (i == 99));
            end
        end
        wait_drain("ep6 wrap drain");

        // Reset mid-packet
        for (int i = 0; i < 5; i++) ep6_write(8'(8'hC0 + i), 0);
        idle_bus();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midreset flags", 32'(bus.fx2_flags), 32'h6);
        check("midreset host_in_valid", 32'(host_in_valid), 32'd0);
        check("midreset errors", 32'({err_underrun, err_overflow}), 32'd0);
        tick();
        ep6_exp.push_back({1'b0, 8'h11});
        ep6_exp.push_back({1'b0, 8'h22});
        ep6_exp.push_back({1'b1, 8'h33});
        ep6_write(8'h11, 0);
        ep6_write(8'h22, 0);
        ep6_write(8'h33, 1);
        wait_drain("post reset drain");
        idle_bus();
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fx2_slave_fifo_model.md
Name: fx2_slave_fifo_model

Overview:
- Synthesizable emulation of the FX2 slave-FIFO endpoint side: the far end of the interface the FPGA master drives.
- EP2 (OUT) buffers command bytes supplied by a host-side stream; the FPGA master reads them via slrd/sloe.
- EP6 (IN) accepts sample/reply bytes written via slwr/pktend and releases them to the host side only as committed packets.
- Used in loopback builds and benches in place of the real FX2, sharing the same fx2_clk domain.

Parameters:
- DEPTH, 512, entries per endpoint FIFO (power of two).
- PKT_SIZE, 512, EP6 bytes that auto-commit a packet.
- AFULL_LEVEL, 480, EP6 occupancy at or above which the almost-full flag asserts.

Ports:
- fx2_clk  input  1  sole clock.
- reset_n  input  1  synchronous, active-low reset.
- fx2_fifoadr  input  2  endpoint select: 2'b00 = EP2, 2'b10 = EP6; other codes select nothing.
- fx2_slrd  input  1  active-low read strobe.
- fx2_slwr  input  1  active-low write strobe.
- fx2_sloe  input  1  active-low output enable.
- fx2_pktend  input  1  active-low packet end.
- fx2_fd  inout  8  data bus.
- fx2_flags  output  3  [0] EP2 empty_n; [1] EP6 full_n; [2] EP6 almost_full_n.
- host_out_data  input  8  command byte into EP2.
- host_out_valid  input  1  host offers a byte.
- host_out_ready  output  1  EP2 not full.
- host_in_data  output  8  committed EP6 byte.
- host_in_last  output  1  byte ends its packet.
- host_in_valid  output  1  committed byte available.
- host_in_ready  input  1  host accepts the byte.
- host_in_zlp  output  1  one-cycle pulse on a zero-length packet commit.
- err_underrun  output  1  sticky: slrd issued to EP2 while empty.
- err_overflow  output  1  sticky: slwr issued to EP6 while full.

Behaviour:
- Reset (reset_n low at an edge):
  - Both FIFOs empty; all pointers and counts 0.
  - fx2_flags = 3'b110.
  - host_out_ready = 1; host_in_valid, host_in_last, host_in_zlp = 0.
  - err_* = 0; fx2_fd released.
  - Reset mid-packet discards all uncommitted and committed data.
- fx2_fd drive: EP2 head byte is driven combinationally when fx2_sloe = 0 and fx2_fifoadr = 00. Otherwise fx2_fd is high-Z. When EP2 is empty and driven, the bus shows 8'h00.
- EP2 push: a host_out_valid & host_out_ready edge writes host_out_data.
- EP2 pop: an edge with fx2_slrd = 0 and fifoadr = 00 pops the entry if non-empty. The new head appears on fd after that edge.
- EP2 read while empty: no state change except err_underrun set.
- EP2 simultaneous push and pop: count is unchanged.
- Flags are registered. Each reflects post-edge state, so there is 1-cycle latency from the causing edge to the flag.
  - flags[0] = (EP2 count != 0).
  - flags[1] = (EP6 count != DEPTH).
  - flags[2] = (EP6 count < AFULL_LEVEL).
- EP6 write: an edge with fx2_slwr = 0 and fifoadr = 10 stores {last=0, fd} when not full. When full, the byte is dropped and err_overflow is set.
- EP6 packet state: uncommitted byte count ucnt, plus commit pointer cptr.
  - A write that makes ucnt == PKT_SIZE sets last on that entry, advances cptr past it, and clears ucnt.
- pktend: an edge with fx2_pktend = 0 and fifoadr = 10 behaves as follows.
  - If ucnt > 0: set last on the newest entry, commit, and clear ucnt.
  - If ucnt = 0: pulse host_in_zlp for one cycle; no FIFO change.
  - Simultaneous slwr and pktend: the write happens first, and the commit includes that byte.
  - Simultaneous auto-commit and pktend: the packet commits once, with no ZLP.
- Host drain: host_in_valid = (rd_ptr != cptr). host_in_data and host_in_last come from the head. The entry pops on a valid & ready edge.
- Pointer width: pointers are log2(DEPTH)+1 bits, and full/empty is decided by the MSB-differing compare. Wrap-around is seamless.
- Strobes with any other fifoadr code are ignored; no error is flagged.

Decomposition:
- Package fx2_model_pkg holds:
  - EP2_ADDR = 2'b00, EP6_ADDR = 2'b10.
  - Flag bit indices FLAG_EP2_EMPTY_N = 0, FLAG_EP6_FULL_N = 1, FLAG_EP6_AFULL_N = 2.
  - Typedef ep6_entry_t {last, data[7:0]}.
- Sub-module fx2_ep_fifo: a parameterised width/depth synchronous FIFO with count output, instantiated for EP2.
- EP6 is coded inline because it needs commit-pointer and last-bit write-back.

Test Plan:
- Command path: push 8'hA5, 8'h3C on host_out → flags[0] rises 1 cycle later. With sloe = 0 and fifoadr = 00, fd = A5. After one slrd edge fd = 3C. After the second, flags[0] = 0 and fd = 00.
- Packet commit: write 3 bytes 01, 02, 03 to EP6 → host_in_valid stays 0. Assert pktend → host sees 01, 02, 03 with last only on 03.
- Auto-commit: write PKT_SIZE bytes with no pktend → 512 bytes delivered, last on byte 511, ucnt = 0.
- ZLP and simultaneity: pktend with ucnt = 0 → host_in_zlp pulses one cycle. Same-edge slwr(7E) + pktend → single 1-byte packet, last = 1.
- Boundaries: fill EP6 to DEPTH → flags[1] = 0 and flags[2] = 0. An extra write sets err_overflow and the data is unchanged. slrd on empty EP2 sets err_underrun. Wrap both FIFOs 3× with no data corruption.
- Reset mid-packet: 5 uncommitted bytes, then reset_n low for 1 cycle → all flags = 110, host_in_valid = 0, and a subsequent packet is delivered intact.
